// File: rtl/mem_data_router_pkg.sv
// Shared constants and helpers for mem_data_router.
// Defining DUAL_RAIL_EN selects the dual-rail word format (two wires per logical bit).
package mem_data_router_pkg;

   localparam logic [1:0] DR_NULL    = 2'b00;
   localparam logic [1:0] DR_FALSE   = 2'b01;
   localparam logic [1:0] DR_TRUE    = 2'b10;
   localparam logic [1:0] DR_ILLEGAL = 2'b11;

   localparam int unsigned DR_MAX_PAIRS = 64;
   localparam int unsigned DR_MAX_W     = 2 * DR_MAX_PAIRS;

`ifdef DUAL_RAIL_EN
   localparam int unsigned RAIL_MULT = 2;
`else
   localparam int unsigned RAIL_MULT = 1;
`endif

   // A word is legal when each of its first 'pairs' rail pairs carries exactly one true rail.
   function automatic logic dr_word_legal(input logic [DR_MAX_W-1:0] word,
                                          input int unsigned          pairs);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < DR_MAX_PAIRS; i++) begin
         case (word[2*i +: 2])
            DR_FALSE, DR_TRUE:   ;
            DR_NULL, DR_ILLEGAL: if (i < pairs) ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/mem_data_router_fifo.sv
// One destination channel: DEPTH-entry FIFO with occupancy count.
// The head word reads as zero while the FIFO is empty.
module mem_data_router_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [CNT_W-1:0] count_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      pop      = pop_i && (cnt_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign count_o = cnt_q;
   assign valid_o = (cnt_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/mem_data_router.sv
// Steers tagged memory words into NUM_CH per-channel FIFOs with sticky error flags.
// Define DUAL_RAIL_EN for dual-rail words with rail-pair legality checking.
module mem_data_router
   import mem_data_router_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = $clog2(NUM_CH),
   parameter int unsigned IN_W   = RAIL_MULT * DATA_W,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TAG_W-1:0]        in_tag,
   input  logic [IN_W-1:0]         in_data,
   output logic [NUM_CH-1:0]       out_valid,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic [NUM_CH*IN_W-1:0]  out_data,
   output logic [NUM_CH*CNT_W-1:0] ch_count,
   output logic                    err_tag,
   output logic                    err_code
);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] push;
   logic              tag_ok;
   logic              code_ok;
   logic              sel_full;
   logic              xfer;
   logic              err_tag_q, err_tag_d;
   logic              err_code_q, err_code_d;

`ifdef DUAL_RAIL_EN
   assign code_ok = dr_word_legal(DR_MAX_W'(in_data), DATA_W);
`else
   assign code_ok = 1'b1;
`endif

   // Illegal words are always accepted (and dropped); only a full legal target stalls.
   always_comb begin
      tag_ok   = (32'(in_tag) < NUM_CH);
      sel_full = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (32'(in_tag) == c) sel_full = full[c];
      end
      in_ready = !(tag_ok && code_ok && sel_full);
      xfer     = in_valid && in_ready && !rst;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         push[c] = xfer && tag_ok && code_ok && (32'(in_tag) == c);
      end
      err_tag_d  = err_tag_q  | (xfer && !tag_ok);
      err_code_d = err_code_q | (xfer && !code_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_tag_q  <= 1'b0;
         err_code_q <= 1'b0;
      end else begin
         err_tag_q  <= err_tag_d;
         err_code_q <= err_code_d;
      end
   end

   assign err_tag  = err_tag_q;
   assign err_code = err_code_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mem_data_router_fifo #(
         .WIDTH (IN_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[c]),
         .pop_i   (out_ready[c]),
         .data_i  (in_data),
         .count_o (ch_count[c*CNT_W +: CNT_W]),
         .valid_o (out_valid[c]),
         .data_o  (out_data[c*IN_W +: IN_W])
      );
      assign full[c] = (ch_count[c*CNT_W +: CNT_W] == CNT_W'(DEPTH));
   end

endmodule

// File: tb/tb_mem_data_router.sv
// Self-checking bench for mem_data_router (3 channels, depth 4) against a queue-based model.
module tb_mem_data_router;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned NUM_CH = 3;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned TAG_W  = 2;
   localparam int unsigned CNT_W  = 3;
`ifdef DUAL_RAIL_EN
   localparam int unsigned IN_W = 2 * DATA_W;
`else
   localparam int unsigned IN_W = DATA_W;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [TAG_W-1:0]        in_tag;
   logic [IN_W-1:0]         in_data;
   logic [NUM_CH-1:0]       out_valid;
   logic [NUM_CH-1:0]       out_ready;
   logic [NUM_CH*IN_W-1:0]  out_data;
   logic [NUM_CH*CNT_W-1:0] ch_count;
   logic                    err_tag;
   logic                    err_code;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [IN_W-1:0] mq [NUM_CH][$];
   logic            m_etag;
   logic            m_ecode;

   mem_data_router #(
      .DATA_W (DATA_W),
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tag    (in_tag),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ch_count  (ch_count),
      .err_tag   (err_tag),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [IN_W-1:0] enc(input logic [DATA_W-1:0] b);
      logic [IN_W-1:0] w;
`ifdef DUAL_RAIL_EN
      for (int i = 0; i < int'(DATA_W); i++) begin
         w[2*i+1] = b[i];
         w[2*i]   = ~b[i];
      end
`else
      w = b;
`endif
      return w;
   endfunction

   function automatic logic legal(input logic [IN_W-1:0] w);
      logic ok;
      ok = 1'b1;
`ifdef DUAL_RAIL_EN
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (w[2*i +: 2] != 2'b01 && w[2*i +: 2] != 2'b10) ok = 1'b0;
      end
`else
      if (w === 'x) ok = 1'b0;
`endif
      return ok;
   endfunction

   function automatic logic [IN_W-1:0] rand_word();
      logic [IN_W-1:0] w;
      w = enc(DATA_W'($urandom));
`ifdef DUAL_RAIL_EN
      if ($urandom_range(0, 5) == 0) begin
         int p;
         p = int'($urandom_range(0, DATA_W - 1));
         w[2*p +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      end
`endif
      return w;
   endfunction

   task automatic check_outputs();
      for (int c = 0; c < int'(NUM_CH); c++) begin
         logic            ev;
         logic [IN_W-1:0] ed;
         ev = (mq[c].size() != 0);
         ed = ev ? mq[c][0] : '0;
         check($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(ev));
         check($sformatf("out_data[%0d]", c), 64'(out_data[c*IN_W +: IN_W]), 64'(ed));
         check($sformatf("ch_count[%0d]", c), 64'(ch_count[c*CNT_W +: CNT_W]), 64'(mq[c].size()));
      end
      check("err_tag", 64'(err_tag), 64'(m_etag));
      check("err_code", 64'(err_code), 64'(m_ecode));
   endtask

   // One clock cycle: drive, check in_ready, advance the model at the edge, check outputs.
   task automatic step(input logic v, input logic [TAG_W-1:0] t, input logic [IN_W-1:0] d,
                       input logic [NUM_CH-1:0] r);
      logic tag_ok, ok, full, exp_rdy;
      in_valid  = v;
      in_tag    = t;
      in_data   = d;
      out_ready = r;
      tag_ok    = (int'(t) < int'(NUM_CH));
      ok        = legal(d);
      full      = 1'b0;
      if (tag_ok) full = (mq[t].size() == int'(DEPTH));
      exp_rdy   = !(tag_ok && ok && full);
      #1;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (r[c] && mq[c].size() != 0) void'(mq[c].pop_front());
      end
      if (v && exp_rdy) begin
         if (!tag_ok) m_etag = 1'b1;
         if (!ok) m_ecode = 1'b1;
         if (tag_ok && ok) mq[t].push_back(d);
      end
      #1;
      check_outputs();
   endtask

   task automatic clear_model();
      for (int c = 0; c < int'(NUM_CH); c++) mq[c].delete();
      m_etag  = 1'b0;
      m_ecode = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_tag    = '0;
      in_data   = '0;
      out_ready = '0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check("in_ready_rst", 64'(in_ready), 64'(1));
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // First word lands in channel 0 one cycle later.
      step(1'b1, 2'd0, enc(8'hA5), 3'b000);
      step(1'b0, 2'd0, '0, 3'b001);

      // Fill channel 1; its fifth word stalls while channel 0 keeps accepting.
      for (int k = 1; k <= 4; k++) step(1'b1, 2'd1, enc(DATA_W'(k)), 3'b000);
      step(1'b1, 2'd1, enc(8'd5), 3'b000);
      step(1'b1, 2'd0, enc(8'd6), 3'b000);
      step(1'b1, 2'd1, enc(8'd5), 3'b010);
      step(1'b1, 2'd1, enc(8'd5), 3'b000);
      for (int k = 0; k < 6; k++) step(1'b0, 2'd0, '0, 3'b011);

      // Out-of-range tag is swallowed and flagged.
      step(1'b1, 2'd3, enc(8'd7), 3'b000);
      step(1'b0, 2'd0, '0, 3'b000);

`ifdef DUAL_RAIL_EN
      step(1'b1, 2'd0, 16'h5556, 3'b000);
      step(1'b1, 2'd0, 16'h5557, 3'b000);
      step(1'b1, 2'd3, 16'h0000, 3'b001);
`endif

      // Asynchronous reset with words in flight.
      for (int k = 0; k < 3; k++) step(1'b1, 2'd0, enc(DATA_W'(8'h10 + k)), 3'b000);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      clear_model();
      check("in_ready_rst2", 64'(in_ready), 64'(1));
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 2'd0, enc(8'h3C), 3'b000);
      step(1'b0, 2'd0, '0, 3'b000);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         logic [TAG_W-1:0] t;
         t = ($urandom_range(0, 7) == 0) ? 2'd3 : TAG_W'($urandom_range(0, NUM_CH - 1));
         step($urandom_range(0, 4) != 0, t, rand_word(),
              NUM_CH'($urandom) & NUM_CH'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
